// File: rtl/debug_scan_slave.sv
// debug_scan_slave: sysclk-side debug scan slave; scan length check enabled by DEBUG_SCAN_LEN_CHECK_EN
module debug_scan_slave #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int NUM_CH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [IR_WIDTH-1:0]          ir_in,
    input  logic                         vs_uir,
    input  logic                         vs_cdr,
    input  logic                         vs_sdr,
    input  logic                         shift_en,
    input  logic                         tdi,
    input  logic                         vs_udr,
    input  logic [NUM_CH*DR_WIDTH-1:0]   cap_data,
    output logic                         tdo,
    output logic [IR_WIDTH-1:0]          ir_out,
    output logic [DR_WIDTH-1:0]          jdo,
    output logic [IR_WIDTH-1:0]          upd_ir,
    output logic                         upd_valid,
    input  logic                         upd_ready,
    output logic                         overrun,
    output logic                         short_scan,
    input  logic                         clr_status
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    logic [0:0]          state;
    logic [DR_WIDTH-1:0] sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic [DR_WIDTH-1:0] ch [NUM_CH];
    logic                udr_ev, cap_ev, shift_ev, len_ok, cand, accept;
    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch[g] = cap_data[g*DR_WIDTH +: DR_WIDTH];
    end
    // update-DR wins over a coincident capture-DR
    assign udr_ev   = state == SHIFT && vs_udr;
    assign cap_ev   = vs_cdr && !vs_udr;
    assign shift_ev = state == SHIFT && vs_sdr && shift_en && !vs_cdr && !vs_udr;
    assign cand     = udr_ev && len_ok;
    assign accept   = cand && (!upd_valid || upd_ready);
    assign tdo      = sr[0];
    assign ir_out   = IR_WIDTH'({overrun, short_scan});
`ifdef DEBUG_SCAN_LEN_CHECK_EN
    localparam int CW = $clog2(DR_WIDTH + 2);
    logic [CW-1:0] cnt;
    assign len_ok = cnt == CW'(DR_WIDTH);
    always_ff @(posedge clk) begin
        cnt        <= reset ? '0 : cap_ev ? '0 :
                      (shift_ev && cnt != CW'(DR_WIDTH + 1)) ? cnt + 1'b1 : cnt;
        short_scan <= reset ? 1'b0 : (udr_ev && !len_ok) || (short_scan && !clr_status);
    end
`else
    assign len_ok     = 1'b1;
    assign short_scan = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            ir_q      <= '0;
            jdo       <= '0;
            upd_ir    <= '0;
            upd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= udr_ev ? IDLE : cap_ev ? SHIFT : state;
            sr        <= cap_ev ? ch[ir_q] : shift_ev ? {tdi, sr[DR_WIDTH-1:1]} : sr;
            ir_q      <= (vs_uir && state == IDLE) ? ir_in : ir_q;
            jdo       <= accept ? sr : jdo;
            upd_ir    <= accept ? ir_q : upd_ir;
            upd_valid <= accept || (upd_valid && !upd_ready);
            overrun   <= (cand && !accept) || (overrun && !clr_status);
        end
    end
endmodule

// File: tb/tb_debug_scan_slave.sv
// tb_debug_scan_slave: directed scans checked every cycle against a queue-based scan model
module tb_debug_scan_slave;
    localparam int W = 38, IW = 2, NC = 4;
`ifdef DEBUG_SCAN_LEN_CHECK_EN
    localparam bit LEN = 1'b1;
`else
    localparam bit LEN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic [IW-1:0] ir_in = '0;
    logic vs_uir = 0, vs_cdr = 0, vs_sdr = 0, shift_en = 0, tdi = 0, vs_udr = 0;
    logic upd_ready = 0, clr_status = 0;
    logic [NC*W-1:0] cap_data;
    logic tdo, upd_valid, overrun, short_scan;
    logic [IW-1:0] ir_out, upd_ir;
    logic [W-1:0] jdo;
    int checks = 0, errors = 0;
    bit chk_on = 0;
    bit q[$];
    int n;
    bit in_scan, m_valid, m_ovr, m_short;
    logic [IW-1:0] m_irq, m_upd_ir;
    logic [W-1:0] m_jdo;
    logic [7:0] seq = 8'hA5;

    debug_scan_slave #(.DR_WIDTH(W), .IR_WIDTH(IW), .NUM_CH(NC)) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .shift_en(shift_en), .tdi(tdi), .vs_udr(vs_udr),
        .cap_data(cap_data), .tdo(tdo), .ir_out(ir_out), .jdo(jdo), .upd_ir(upd_ir),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .overrun(overrun),
        .short_scan(short_scan), .clr_status(clr_status));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] q_word();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = q[i];
        return r;
    endfunction

    task automatic model_step();
        bit upd, cand, acc, was_scan;
        logic [W-1:0] c;
        if (reset) begin
            q.delete();
            for (int i = 0; i < W; i++) q.push_back(1'b0);
            n = 0; in_scan = 0; m_irq = '0; m_upd_ir = '0; m_jdo = '0;
            m_valid = 0; m_ovr = 0; m_short = 0;
            return;
        end
        was_scan = in_scan;
        upd  = in_scan && vs_udr;
        cand = upd && (!LEN || n == W);
        acc  = cand && (!m_valid || upd_ready);
        if (acc) begin
            m_jdo = q_word();
            m_upd_ir = m_irq;
        end
        m_valid = acc || (m_valid && !upd_ready);
        m_ovr   = (cand && !acc) || (m_ovr && !clr_status);
        m_short = (upd && LEN && n != W) || (m_short && !clr_status);
        if (upd) in_scan = 0;
        else if (vs_cdr) begin
            c = cap_data[m_irq*W +: W];
            q.delete();
            for (int i = 0; i < W; i++) q.push_back(c[i]);
            n = 0;
            in_scan = 1;
        end else if (in_scan && vs_sdr && shift_en) begin
            void'(q.pop_front());
            q.push_back(tdi);
            n++;
        end
        if (!was_scan && vs_uir) m_irq = ir_in;
    endtask

    always @(negedge clk) if (chk_on) begin
        chk("tdo", tdo, q[0]);
        chk("jdo", jdo, m_jdo);
        chk("upd_ir", upd_ir, m_upd_ir);
        chk("upd_valid", upd_valid, m_valid);
        chk("overrun", overrun, m_ovr);
        chk("short_scan", short_scan, m_short);
        chk("ir_out", ir_out, {m_ovr, m_short});
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic set_ir(input logic [IW-1:0] v);
        ir_in = v; vs_uir = 1; cyc(); vs_uir = 0;
    endtask
    task automatic capture();
        vs_cdr = 1; cyc(); vs_cdr = 0;
    endtask
    task automatic shift(input logic b);
        vs_sdr = 1; shift_en = 1; tdi = b; cyc(); vs_sdr = 0; shift_en = 0;
    endtask
    task automatic update();
        vs_udr = 1; cyc(); vs_udr = 0;
    endtask

    initial begin
        cap_data = {38'h3C_0F0F_F0F0, 38'h2_A5A5_A5A5, 38'h15_5555_AAAA, 38'h01_2345_6789};
        repeat (3) cyc();
        reset = 0;
        chk_on = 1;
        chk("rst_jdo", jdo, 0);
        chk("rst_valid", upd_valid, 0);
        chk("rst_tdo", tdo, 0);
        set_ir(2);
        capture();
        for (int k = 0; k < W; k++) begin
            if (k < 8) chk("tdo_seq", tdo, seq[k]);
            shift(1);
        end
        update();
        chk("scan1_jdo", jdo, 38'h3F_FFFF_FFFF);
        chk("scan1_ir", upd_ir, 2);
        chk("scan1_valid", upd_valid, 1);
        capture();
        for (int k = 0; k < W; k++) shift(0);
        update();
        chk("ovr_set", overrun, 1);
        chk("ovr_jdo", jdo, 38'h3F_FFFF_FFFF);
        clr_status = 1; cyc(); clr_status = 0;
        chk("ovr_clr", overrun, 0);
        set_ir(1);
        capture();
        for (int k = 0; k < W; k++) shift(logic'(k % 2));
        upd_ready = 1;
        update();
        chk("b2b_jdo", jdo, 38'h2A_AAAA_AAAA);
        chk("b2b_valid", upd_valid, 1);
        chk("b2b_ir", upd_ir, 1);
        chk("b2b_ovr", overrun, 0);
        cyc();
        chk("drain", upd_valid, 0);
        set_ir(3);
        capture();
        for (int k = 0; k < W - 1; k++) shift(0);
        update();
`ifdef DEBUG_SCAN_LEN_CHECK_EN
        chk("short_flag", short_scan, 1);
        chk("short_valid", upd_valid, 0);
        chk("short_irout", ir_out, 2'b01);
        clr_status = 1; cyc(); clr_status = 0;
        chk("short_clr", short_scan, 0);
`else
        chk("short_jdo", jdo, 38'h1);
        chk("short_valid", upd_valid, 1);
        cyc();
`endif
        set_ir(0);
        capture();
        shift_en = 1;
        repeat (3) cyc();
        shift_en = 0;
        chk("sdr0_tdo", tdo, 1);
        ir_in = 3; vs_uir = 1; cyc(); vs_uir = 0;
        for (int k = 0; k < W; k++) shift(1);
        update();
        chk("uir_shift_ir", upd_ir, 0);
        cyc();
        capture();
        for (int k = 0; k < W; k++) shift(1);
        vs_cdr = 1; vs_udr = 1; cyc(); vs_cdr = 0; vs_udr = 0;
        chk("cdr_udr_jdo", jdo, 38'h3F_FFFF_FFFF);
        update();
        cyc();
        capture();
        for (int k = 0; k < 10; k++) shift(1);
        reset = 1; cyc(); reset = 0;
        chk("midrst_jdo", jdo, 0);
        chk("midrst_tdo", tdo, 0);
        update();
        chk("midrst_udr", upd_valid, 0);
        repeat (2) cyc();
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
